// File: rtl/am29xx_pkg.sv
// rtl/am29xx_pkg.sv - shared encodings for the am2901 ALU slice and am2909/am2911 sequencers
package am29xx_pkg;

    localparam int ALU_W = 8;
    localparam int SEQ_W = 12;

    typedef enum logic [2:0] {
        SRC_AQ = 3'd0,
        SRC_AB = 3'd1,
        SRC_ZQ = 3'd2,
        SRC_ZB = 3'd3,
        SRC_ZA = 3'd4,
        SRC_DA = 3'd5,
        SRC_DQ = 3'd6,
        SRC_DZ = 3'd7
    } src_e;

    typedef enum logic [2:0] {
        OP_ADD   = 3'd0,
        OP_SUBR  = 3'd1,
        OP_SUBS  = 3'd2,
        OP_OR    = 3'd3,
        OP_AND   = 3'd4,
        OP_NOTRS = 3'd5,
        OP_EXOR  = 3'd6,
        OP_EXNOR = 3'd7
    } op_e;

    typedef enum logic [2:0] {
        DST_QREG  = 3'd0,
        DST_NOP   = 3'd1,
        DST_RAMA  = 3'd2,
        DST_RAMF  = 3'd3,
        DST_RAMQD = 3'd4,
        DST_RAMD  = 3'd5,
        DST_RAMQU = 3'd6,
        DST_RAMU  = 3'd7
    } dest_e;

    typedef enum logic [1:0] {
        SEL_PC  = 2'd0,
        SEL_AR  = 2'd1,
        SEL_STK = 2'd2,
        SEL_D   = 2'd3
    } seq_sel_e;

endpackage

// File: rtl/am2901.sv
// rtl/am2901.sv - 4-bit ALU/register slice, shift pins and output enable removed
module am2901
    import am29xx_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] din,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [2:0] src,
    input  logic [2:0] op,
    input  logic [2:0] dest,
    input  logic       cin,
    output logic [3:0] yout,
    output logic       cout,
    output logic       f0,
    output logic       f3,
    output logic       ovr
);

    logic [3:0] ram_q [16];
    logic [3:0] ram_d [16];
    logic [3:0] q_q, q_d;
    logic [3:0] a_val, b_val, r, s, r_op, s_op, f;
    logic [4:0] sum;
    logic       c3;

    always_comb begin
        a_val = ram_q[a];
        b_val = ram_q[b];
        r = 4'h0;
        s = 4'h0;
        case (src_e'(src))
            SRC_AQ: begin r = a_val; s = q_q;   end
            SRC_AB: begin r = a_val; s = b_val; end
            SRC_ZQ: begin r = 4'h0;  s = q_q;   end
            SRC_ZB: begin r = 4'h0;  s = b_val; end
            SRC_ZA: begin r = 4'h0;  s = a_val; end
            SRC_DA: begin r = din;   s = a_val; end
            SRC_DQ: begin r = din;   s = q_q;   end
            SRC_DZ: begin r = din;   s = 4'h0;  end
        endcase

        r_op = (op_e'(op) == OP_SUBR) ? ~r : r;
        s_op = (op_e'(op) == OP_SUBS) ? ~s : s;
        sum  = {1'b0, r_op} + {1'b0, s_op} + {4'b0, cin};
        // carry into bit 3 recovered from the sum bit and its two operand bits
        c3   = r_op[3] ^ s_op[3] ^ sum[3];

        f    = sum[3:0];
        cout = 1'b0;
        ovr  = 1'b0;
        case (op_e'(op))
            OP_ADD, OP_SUBR, OP_SUBS: begin
                cout = sum[4];
                ovr  = c3 ^ sum[4];
            end
            OP_OR:    f = r | s;
            OP_AND:   f = r & s;
            OP_NOTRS: f = ~r & s;
            OP_EXOR:  f = r ^ s;
            OP_EXNOR: f = ~(r ^ s);
        endcase

        f0   = (f == 4'h0);
        f3   = f[3];
        yout = (dest_e'(dest) == DST_RAMA) ? a_val : f;
    end

    always_comb begin
        ram_d = ram_q;
        q_d   = q_q;
        case (dest_e'(dest))
            DST_QREG:  q_d = f;
            DST_NOP:   ;
            DST_RAMA,
            DST_RAMF:  ram_d[b] = f;
            DST_RAMQD: begin
                ram_d[b] = {1'b0, f[3:1]};
                q_d      = {1'b0, q_q[3:1]};
            end
            DST_RAMD:  ram_d[b] = {1'b0, f[3:1]};
            DST_RAMQU: begin
                ram_d[b] = {f[2:0], 1'b0};
                q_d      = {q_q[2:0], 1'b0};
            end
            DST_RAMU:  ram_d[b] = {f[2:0], 1'b0};
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            q_q <= 4'h0;
            for (int i = 0; i < 16; i++) begin
                ram_q[i] <= 4'h0;
            end
        end else begin
            q_q   <= q_d;
            ram_q <= ram_d;
        end
    end

endmodule

// File: rtl/am2909.sv
// rtl/am2909.sv - full sequencer slice with separate R and OR inputs
module am2909 (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] din,
    input  logic [3:0] rin,
    input  logic [3:0] orin,
    input  logic       s0,
    input  logic       s1,
    input  logic       zero,
    input  logic       cin,
    input  logic       re,
    input  logic       fe,
    input  logic       pup,
    output logic [3:0] yout,
    output logic       cout
);

    am29xx_seq_core u_core (
        .clock (clock),
        .reset (reset),
        .din   (din),
        .rin   (rin),
        .orin  (orin),
        .s0    (s0),
        .s1    (s1),
        .zero  (zero),
        .cin   (cin),
        .re    (re),
        .fe    (fe),
        .pup   (pup),
        .yout  (yout),
        .cout  (cout)
    );

endmodule

// File: rtl/am2911.sv
// rtl/am2911.sv - reduced sequencer slice; AR loads from D and there is no OR input
module am2911 (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] din,
    input  logic       s0,
    input  logic       s1,
    input  logic       zero,
    input  logic       cin,
    input  logic       re,
    input  logic       fe,
    input  logic       pup,
    output logic [3:0] yout,
    output logic       cout
);

    am29xx_seq_core u_core (
        .clock (clock),
        .reset (reset),
        .din   (din),
        .rin   (din),
        .orin  (4'h0),
        .s0    (s0),
        .s1    (s1),
        .zero  (zero),
        .cin   (cin),
        .re    (re),
        .fe    (fe),
        .pup   (pup),
        .yout  (yout),
        .cout  (cout)
    );

endmodule

// File: rtl/am29xx_seq_core.sv
// rtl/am29xx_seq_core.sv - 4-bit sequencer slice: uPC, AR, 4-deep stack, address mux, carry
module am29xx_seq_core
    import am29xx_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] din,
    input  logic [3:0] rin,
    input  logic [3:0] orin,
    input  logic       s0,
    input  logic       s1,
    input  logic       zero,
    input  logic       cin,
    input  logic       re,
    input  logic       fe,
    input  logic       pup,
    output logic [3:0] yout,
    output logic       cout
);

    logic [3:0] upc_q, upc_d;
    logic [3:0] ar_q, ar_d;
    logic [1:0] sp_q, sp_d;
    logic [3:0] stk_q [4];
    logic [3:0] stk_d [4];
    logic [3:0] mux;

    always_comb begin
        mux = upc_q;
        case (seq_sel_e'({s1, s0}))
            SEL_PC:  mux = upc_q;
            SEL_AR:  mux = ar_q;
            SEL_STK: mux = stk_q[sp_q];
            SEL_D:   mux = din;
        endcase
        yout = zero ? (mux | orin) : 4'h0;
        cout = cin & (yout == 4'hF);

        // with zero low yout is already 0, so this also yields uPC <= cin
        upc_d = yout + {3'b0, cin};
        ar_d  = re ? ar_q : rin;

        sp_d  = sp_q;
        stk_d = stk_q;
        if (!fe) begin
            if (pup) begin
                sp_d        = sp_q + 2'd1;
                stk_d[sp_d] = upc_q;
            end else begin
                sp_d = sp_q - 2'd1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            upc_q <= 4'h0;
            ar_q  <= 4'h0;
            sp_q  <= 2'd0;
            for (int i = 0; i < 4; i++) begin
                stk_q[i] <= 4'h0;
            end
        end else begin
            upc_q <= upc_d;
            ar_q  <= ar_d;
            sp_q  <= sp_d;
            stk_q <= stk_d;
        end
    end

endmodule

// File: rtl/am29xx_bitslice.sv
// rtl/am29xx_bitslice.sv - CPU6 slice stack: 2x am2901 ALU and am2909/am2909/am2911 sequencer chain
module am29xx_bitslice
    import am29xx_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic [ALU_W-1:0] alu_din,
    input  logic [3:0]       alu_a,
    input  logic [3:0]       alu_b,
    input  logic [2:0]       alu_src,
    input  logic [2:0]       alu_op,
    input  logic [2:0]       alu_dest,
    input  logic             alu_cin,
    output logic [ALU_W-1:0] alu_y,
    output logic             alu_cout,
    output logic             alu_f0,
    output logic             alu_f3,
    output logic             alu_ovr,
    output logic [3:0]       alu_lo_flags,
    input  logic [SEQ_W-1:0] seq_din,
    input  logic [7:0]       seq_rin,
    input  logic [7:0]       seq_orin,
    input  logic             seq_s0,
    input  logic             seq_s1,
    input  logic             seq_zero,
    input  logic             seq_cin,
    input  logic             seq_re,
    input  logic             seq_fe,
    input  logic             seq_pup,
    output logic [SEQ_W-1:0] seq_y,
    output logic             seq_cout
);

    logic lo_cout, lo_f0, lo_f3, lo_ovr, hi_f0;
    logic c_mid, c_hi;

    am2901 u_alu_lo (
        .clock (clock),
        .reset (reset),
        .din   (alu_din[3:0]),
        .a     (alu_a),
        .b     (alu_b),
        .src   (alu_src),
        .op    (alu_op),
        .dest  (alu_dest),
        .cin   (alu_cin),
        .yout  (alu_y[3:0]),
        .cout  (lo_cout),
        .f0    (lo_f0),
        .f3    (lo_f3),
        .ovr   (lo_ovr)
    );

    am2901 u_alu_hi (
        .clock (clock),
        .reset (reset),
        .din   (alu_din[7:4]),
        .a     (alu_a),
        .b     (alu_b),
        .src   (alu_src),
        .op    (alu_op),
        .dest  (alu_dest),
        .cin   (lo_cout),
        .yout  (alu_y[7:4]),
        .cout  (alu_cout),
        .f0    (hi_f0),
        .f3    (alu_f3),
        .ovr   (alu_ovr)
    );

    // low-nibble flags kept visible for nibble-level arithmetic
    assign alu_lo_flags = {lo_cout, lo_ovr, lo_f3, lo_f0};
    assign alu_f0       = lo_f0 & hi_f0;

    am2909 u_seq_lo (
        .clock (clock),
        .reset (reset),
        .din   (seq_din[3:0]),
        .rin   (seq_rin[3:0]),
        .orin  (seq_orin[3:0]),
        .s0    (seq_s0),
        .s1    (seq_s1),
        .zero  (seq_zero),
        .cin   (seq_cin),
        .re    (seq_re),
        .fe    (seq_fe),
        .pup   (seq_pup),
        .yout  (seq_y[3:0]),
        .cout  (c_mid)
    );

    am2909 u_seq_mid (
        .clock (clock),
        .reset (reset),
        .din   (seq_din[7:4]),
        .rin   (seq_rin[7:4]),
        .orin  (seq_orin[7:4]),
        .s0    (seq_s0),
        .s1    (seq_s1),
        .zero  (seq_zero),
        .cin   (c_mid),
        .re    (seq_re),
        .fe    (seq_fe),
        .pup   (seq_pup),
        .yout  (seq_y[7:4]),
        .cout  (c_hi)
    );

    am2911 u_seq_hi (
        .clock (clock),
        .reset (reset),
        .din   (seq_din[11:8]),
        .s0    (seq_s0),
        .s1    (seq_s1),
        .zero  (seq_zero),
        .cin   (c_hi),
        .re    (seq_re),
        .fe    (seq_fe),
        .pup   (seq_pup),
        .yout  (seq_y[11:8]),
        .cout  (seq_cout)
    );

endmodule

// File: tb/tb_am29xx_bitslice.sv
// tb/tb_am29xx_bitslice.sv - randomized bench with behavioural model for the CPU6 slice stack
module tb_am29xx_bitslice;

    logic        clock;
    logic        reset;
    logic [7:0]  alu_din;
    logic [3:0]  alu_a, alu_b;
    logic [2:0]  alu_src, alu_op, alu_dest;
    logic        alu_cin;
    logic [7:0]  alu_y;
    logic        alu_cout, alu_f0, alu_f3, alu_ovr;
    logic [3:0]  alu_lo_flags;
    logic [11:0] seq_din;
    logic [7:0]  seq_rin, seq_orin;
    logic        seq_s0, seq_s1, seq_zero, seq_cin, seq_re, seq_fe, seq_pup;
    logic [11:0] seq_y;
    logic        seq_cout;

    int checks = 0;
    int failures = 0;

    am29xx_bitslice dut (
        .clock        (clock),
        .reset        (reset),
        .alu_din      (alu_din),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_src      (alu_src),
        .alu_op       (alu_op),
        .alu_dest     (alu_dest),
        .alu_cin      (alu_cin),
        .alu_y        (alu_y),
        .alu_cout     (alu_cout),
        .alu_f0       (alu_f0),
        .alu_f3       (alu_f3),
        .alu_ovr      (alu_ovr),
        .alu_lo_flags (alu_lo_flags),
        .seq_din      (seq_din),
        .seq_rin      (seq_rin),
        .seq_orin     (seq_orin),
        .seq_s0       (seq_s0),
        .seq_s1       (seq_s1),
        .seq_zero     (seq_zero),
        .seq_cin      (seq_cin),
        .seq_re       (seq_re),
        .seq_fe       (seq_fe),
        .seq_pup      (seq_pup),
        .seq_y        (seq_y),
        .seq_cout     (seq_cout)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Behavioural model: 8-bit ALU with nibble-local shifts, 12-bit sequencer
    logic [7:0]  m_ram [16];
    logic [7:0]  m_q;
    logic [11:0] m_pc, m_ar;
    logic [11:0] m_stk [4];
    logic [1:0]  m_sp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q  = 8'h0;
        m_pc = 12'h0;
        m_ar = 12'h0;
        m_sp = 2'd0;
        for (int i = 0; i < 16; i++) m_ram[i] = 8'h0;
        for (int i = 0; i < 4; i++) m_stk[i] = 12'h0;
    endtask

    task automatic model_alu(output logic [7:0] y, output logic [7:0] f,
                             output logic co, output logic ov,
                             output logic lco, output logic lov);
        logic [7:0] r, s, rr, ss;
        int full, low7, lo4, lo3;
        case (alu_src)
            3'd0: begin r = m_ram[alu_a]; s = m_q;          end
            3'd1: begin r = m_ram[alu_a]; s = m_ram[alu_b]; end
            3'd2: begin r = 8'h0;         s = m_q;          end
            3'd3: begin r = 8'h0;         s = m_ram[alu_b]; end
            3'd4: begin r = 8'h0;         s = m_ram[alu_a]; end
            3'd5: begin r = alu_din;      s = m_ram[alu_a]; end
            3'd6: begin r = alu_din;      s = m_q;          end
            default: begin r = alu_din;   s = 8'h0;         end
        endcase
        rr = (alu_op == 3'd1) ? ~r : r;
        ss = (alu_op == 3'd2) ? ~s : s;
        co = 1'b0; ov = 1'b0; lco = 1'b0; lov = 1'b0;
        if (alu_op < 3'd3) begin
            full = int'(rr) + int'(ss) + int'(alu_cin);
            low7 = int'(rr & 8'h7F) + int'(ss & 8'h7F) + int'(alu_cin);
            lo4  = int'(rr & 8'h0F) + int'(ss & 8'h0F) + int'(alu_cin);
            lo3  = int'(rr & 8'h07) + int'(ss & 8'h07) + int'(alu_cin);
            f    = full[7:0];
            co   = full[8];
            ov   = low7[7] ^ full[8];
            lco  = lo4[4];
            lov  = lo3[3] ^ lo4[4];
        end else begin
            case (alu_op)
                3'd3: f = r | s;
                3'd4: f = r & s;
                3'd5: f = ~r & s;
                3'd6: f = r ^ s;
                default: f = ~(r ^ s);
            endcase
        end
        y = (alu_dest == 3'd2) ? m_ram[alu_a] : f;
    endtask

    task automatic model_seq(output logic [11:0] y, output logic co);
        logic [11:0] mux;
        case ({seq_s1, seq_s0})
            2'd0: mux = m_pc;
            2'd1: mux = m_ar;
            2'd2: mux = m_stk[m_sp];
            default: mux = seq_din;
        endcase
        y  = seq_zero ? (mux | {4'h0, seq_orin}) : 12'h0;
        co = seq_cin && (y == 12'hFFF);
    endtask

    always @(posedge clock or posedge reset) begin : model_update
        logic [7:0]  y, f;
        logic        co, ov, lco, lov, sco;
        logic [11:0] sy, old_pc;
        if (reset) begin
            model_reset();
        end else begin
            model_alu(y, f, co, ov, lco, lov);
            model_seq(sy, sco);
            case (alu_dest)
                3'd0: m_q = f;
                3'd2, 3'd3: m_ram[alu_b] = f;
                3'd4: begin
                    m_ram[alu_b] = (f >> 1) & 8'h77;
                    m_q = (m_q >> 1) & 8'h77;
                end
                3'd5: m_ram[alu_b] = (f >> 1) & 8'h77;
                3'd6: begin
                    m_ram[alu_b] = (f << 1) & 8'hEE;
                    m_q = (m_q << 1) & 8'hEE;
                end
                3'd7: m_ram[alu_b] = (f << 1) & 8'hEE;
                default: ;
            endcase
            old_pc = m_pc;
            m_pc = sy + {11'b0, seq_cin};
            if (!seq_re) m_ar = {seq_din[11:8], seq_rin};
            if (!seq_fe) begin
                if (seq_pup) begin
                    m_sp = m_sp + 2'd1;
                    m_stk[m_sp] = old_pc;
                end else begin
                    m_sp = m_sp - 2'd1;
                end
            end
        end
    end

    always @(negedge clock) begin : compare
        logic [7:0]  ey, ef;
        logic        ec, eo, elc, elo, esc;
        logic [11:0] esy;
        model_alu(ey, ef, ec, eo, elc, elo);
        model_seq(esy, esc);
        check("alu_y",    alu_y, ey);
        check("alu_cout", alu_cout, ec);
        check("alu_ovr",  alu_ovr, eo);
        check("alu_f0",   alu_f0, ef == 8'h0);
        check("alu_f3",   alu_f3, ef[7]);
        check("alu_lo",   alu_lo_flags, {elc, elo, ef[3], ef[3:0] == 4'h0});
        check("seq_y",    seq_y, esy);
        check("seq_cout", seq_cout, esc);
    end

    task automatic cyc();
        @(posedge clock);
        #2;
    endtask

    initial begin
        alu_din = 8'h0; alu_a = 4'h0; alu_b = 4'h0;
        alu_src = 3'd7; alu_op = 3'd3; alu_dest = 3'd1; alu_cin = 1'b0;
        seq_din = 12'h0; seq_rin = 8'h0; seq_orin = 8'h0;
        seq_s0 = 1'b0; seq_s1 = 1'b0; seq_zero = 1'b1; seq_cin = 1'b0;
        seq_re = 1'b1; seq_fe = 1'b1; seq_pup = 1'b0;
        reset = 1'b0;
        #3 reset = 1'b1;
        #1;
        check("rst_alu_y", alu_y, 8'h00);
        check("rst_f0", alu_f0, 1'b1);
        check("rst_cout", alu_cout, 1'b0);
        check("rst_ovr", alu_ovr, 1'b0);
        check("rst_f3", alu_f3, 1'b0);
        check("rst_seq_y", seq_y, 12'h000);
        check("rst_seq_cout", seq_cout, 1'b0);
        cyc();
        reset = 1'b0;

        // ADD: B5 <= 9, then D + A5
        alu_src = 3'd7; alu_op = 3'd0; alu_dest = 3'd3; alu_b = 4'd5; alu_din = 8'h09;
        #1 check("add_load_y", alu_y, 8'h09);
        cyc();
        alu_src = 3'd5; alu_a = 4'd5; alu_din = 8'h08; alu_dest = 3'd1;
        #1;
        check("add_y", alu_y, 8'h11);
        check("add_lo_cout", alu_lo_flags[3], 1'b1);
        check("add_lo_ovr", alu_lo_flags[2], 1'b1);
        check("add_cout", alu_cout, 1'b0);

        // SUBR with Q, then Q shift down
        alu_din = 8'h03; alu_src = 3'd7; alu_op = 3'd0; alu_dest = 3'd0; alu_cin = 1'b0;
        cyc();
        alu_src = 3'd2; alu_op = 3'd1; alu_cin = 1'b1; alu_dest = 3'd1;
        #1;
        check("subr_y", alu_y, 8'h03);
        check("subr_cout", alu_cout, 1'b1);
        check("subr_f0", alu_f0, 1'b0);
        alu_dest = 3'd4;
        cyc();
        alu_op = 3'd3; alu_dest = 3'd1; alu_cin = 1'b0;
        #1 check("subr_qshift", alu_y, 8'h01);

        // shifts stay within each nibble with zero fill
        alu_din = 8'h11; alu_src = 3'd7; alu_op = 3'd3; alu_dest = 3'd0;
        cyc();
        alu_src = 3'd2; alu_dest = 3'd4;
        cyc();
        alu_dest = 3'd1;
        #1 check("qshift_nibble_dn", alu_y, 8'h00);
        alu_din = 8'h48; alu_src = 3'd7; alu_dest = 3'd0;
        cyc();
        alu_src = 3'd2; alu_dest = 3'd6;
        cyc();
        alu_dest = 3'd1;
        #1 check("qshift_nibble_up", alu_y, 8'h80);

        // sequencer carry across all three slices
        seq_s1 = 1'b1; seq_s0 = 1'b1; seq_din = 12'hFF0; seq_cin = 1'b1;
        #1 check("seq_load_d", seq_y, 12'hFF0);
        cyc();
        seq_s1 = 1'b0; seq_s0 = 1'b0;
        repeat (14) cyc();
        #1;
        check("seq_inc_y", seq_y, 12'hFFF);
        check("seq_inc_cout", seq_cout, 1'b1);
        seq_cin = 1'b0;
        #1 check("seq_nocin_cout", seq_cout, 1'b0);
        seq_cin = 1'b1;
        cyc();
        #1;
        check("seq_wrap_y", seq_y, 12'h000);
        check("seq_wrap_cout", seq_cout, 1'b0);

        // push and pop
        seq_s1 = 1'b1; seq_s0 = 1'b1; seq_din = 12'h006;
        cyc();
        seq_fe = 1'b0; seq_pup = 1'b1;
        cyc();
        seq_fe = 1'b1; seq_s0 = 1'b0;
        #1 check("push_stk0", seq_y, 12'h007);
        seq_fe = 1'b0; seq_pup = 1'b0;
        cyc();
        seq_fe = 1'b1;
        #1 check("pop_stk0", seq_y, 12'h000);

        // AR load and OR input
        seq_rin = 8'h0A; seq_re = 1'b0;
        cyc();
        seq_re = 1'b1; seq_s1 = 1'b0; seq_s0 = 1'b1; seq_orin = 8'h01;
        #1 check("ar_or_y", seq_y, 12'h00B);
        seq_zero = 1'b0;
        #1 check("zero_y", seq_y, 12'h000);
        cyc();
        seq_zero = 1'b1; seq_orin = 8'h00; seq_s0 = 1'b0;
        #1 check("zero_upc", seq_y, 12'h001);

        repeat (400) begin
            cyc();
            alu_din  = 8'($urandom);
            alu_a    = 4'($urandom);
            alu_b    = 4'($urandom);
            alu_src  = 3'($urandom);
            alu_op   = 3'($urandom);
            alu_dest = 3'($urandom);
            alu_cin  = 1'($urandom);
            seq_din  = 12'($urandom);
            seq_rin  = 8'($urandom);
            seq_orin = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            seq_s0   = 1'($urandom);
            seq_s1   = 1'($urandom);
            seq_zero = ($urandom_range(0, 7) != 0);
            seq_cin  = 1'($urandom);
            seq_re   = 1'($urandom);
            seq_fe   = 1'($urandom);
            seq_pup  = 1'($urandom);
        end

        // asynchronous reset between edges
        cyc();
        seq_s0 = 1'b0; seq_s1 = 1'b0; seq_zero = 1'b1; seq_cin = 1'b0; seq_orin = 8'h00;
        seq_fe = 1'b1; seq_re = 1'b1;
        alu_src = 3'd1; alu_op = 3'd3; alu_dest = 3'd1; alu_a = 4'd3; alu_b = 4'd7; alu_cin = 1'b0;
        #1 reset = 1'b1;
        #1;
        check("async_seq_y", seq_y, 12'h000);
        check("async_ram_ab", alu_y, 8'h00);
        alu_src = 3'd2;
        #1 check("async_q", alu_y, 8'h00);
        #1 reset = 1'b0;
        seq_cin = 1'b1;
        repeat (15) cyc();
        #1;
        check("post_rst_inc_y", seq_y, 12'h00F);
        check("post_rst_inc_cout", seq_cout, 1'b0);

        cyc();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
